// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants for the serial link: alignment character, lock depth and
// receive FSM encodings (also used by the TX parallel-serial block).
package serial_paralelo_rx_pkg;

    localparam logic [7:0] COMMA          = 8'hBC;
    localparam logic [3:0] SYNC_COUNT_DEF = 4'd4;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    function automatic logic is_comma(input logic [7:0] w);
        return (w == COMMA);
    endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial input and recovered byte outputs of the RX serial-parallel stage.
interface serial_paralelo_rx_if;

    logic       data_in;
    logic [7:0] Salida;
    logic       validSalida;
    logic       active;

    // master: serial source / byte consumer side; slave: the receiver
    modport master (output data_in, input Salida, input validSalida, input active);
    modport slave  (input data_in, output Salida, output validSalida, output active);

endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment on repeated COMMA
// characters, then emits one byte (with valid) every 8 clk_32f edges.
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [3:0] SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic               clk_32f,
    input  logic               reset,
    serial_paralelo_rx_if.slave rx
);

    logic [1:0] state_q, state_d;
    // Only the 7 youngest bits are ever needed: the window appends the live sample.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] bc_cnt_q;
    logic [3:0] bc_next;
    logic [7:0] salida_q;
    logic       valid_q;
    logic       active_q;
    logic [7:0] window;
    logic       boundary;
    logic       comma_w;

    assign window   = {sr_q, rx.data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign comma_w  = is_comma(window);
    assign bc_next  = bc_cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: begin
                if (comma_w) begin
                    state_d = (SYNC_COUNT == 4'd1) ? ST_ACTIVE : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (boundary) begin
                    if (!comma_w) begin
                        state_d = ST_SEARCH;
                    end else if (bc_next == SYNC_COUNT) begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            active_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_ACTIVE) begin
                active_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            salida_q  <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            sr_q <= window[6:0];
            case (state_q)
                ST_SEARCH: begin
                    if (comma_w) begin
                        bit_cnt_q <= 3'd0;
                        bc_cnt_q  <= 4'd1;
                    end
                end
                ST_SYNC: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        bc_cnt_q <= comma_w ? bc_next : 4'd0;
                    end
                end
                ST_ACTIVE: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    // COMMA after lock is idle: drop valid but keep the last byte
                    if (boundary) begin
                        valid_q <= !comma_w;
                        if (!comma_w) begin
                            salida_q <= window;
                        end
                    end
                end
                default: bit_cnt_q <= 3'd0;
            endcase
        end
    end

    assign rx.Salida      = salida_q;
    assign rx.validSalida = valid_q;
    assign rx.active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: fixed vector table, hand-timed sequences and
// random streams, all compared against a whole-history reference model.
module tb_serial_paralelo_rx;

    localparam logic [7:0] M_COMMA = 8'hBC;
    localparam int         M_SC    = 4;

    logic clk_32f = 1'b0;
    logic reset;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_rx_if bus ();

    serial_paralelo_rx dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .rx      (bus)
    );

    typedef struct {
        int         npre;
        logic [7:0] pre;
        int         nbytes;
        logic [79:0] bytes;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl[6];
    int         n_vec = 0;
    int         n_err = 0;
    string      tag;
    logic       hist[$];
    logic [9:0] obs[0:1023];

    function automatic logic [9:0] dut_out();
        return {bus.active, bus.validSalida, bus.Salida};
    endfunction

    // Byte formed by the 8 bits ending at bit p; bits before reset release are zero.
    function automatic logic [7:0] win(int p);
        logic [7:0] w = 8'h00;
        for (int i = p - 7; i <= p; i++) begin
            w = {w[6:0], (i >= 0) ? hist[i] : 1'b0};
        end
        return w;
    endfunction

    // Expected {active, valid, Salida} after the newest bit, recomputed from the whole history.
    function automatic logic [9:0] model();
        int         n = hist.size() - 1;
        int         lock = -1;
        int         s = 0;
        bit         stop = 0;
        logic [7:0] sal = 8'h00;
        logic       val = 1'b0;
        logic [7:0] w;
        if (n < 0) return 10'h000;
        while (!stop && lock < 0 && s <= n) begin
            if (win(s) == M_COMMA) begin
                int k;
                int res;
                k = 1;
                res = 0;
                while (res == 0) begin
                    if (k == M_SC)                       res = 1;
                    else if (s + 8 * k > n)              res = 3;
                    else if (win(s + 8 * k) != M_COMMA)  res = 2;
                    else                                 k++;
                end
                if (res == 1)      lock = s + 8 * (M_SC - 1);
                else if (res == 3) stop = 1;
                else               s = s + 8 * k + 1;
            end else begin
                s++;
            end
        end
        if (lock < 0) return 10'h000;
        for (int b = lock + 8; b <= n; b += 8) begin
            w = win(b);
            val = (w != M_COMMA);
            if (val) sal = w;
        end
        return {1'b1, val, sal};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got act=%b vld=%b Salida=%h, expected act=%b vld=%b Salida=%h",
                     name, got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic step(input logic b, input logic r);
        bus.data_in = b;
        reset       = r;
        @(posedge clk_32f);
        #1;
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() <= 1024) obs[hist.size() - 1] = dut_out();
        end
        check({tag, "_model"}, dut_out(), model());
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(b[i], 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) step(1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        int         nj;

        tbl[0] = '{0, 8'h00, 8, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h3C, 8'hBC, 8'h7E, 16'h0}, 10'h37E};
        tbl[1] = '{3, 8'h05, 5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 40'h0}, 10'h311};
        tbl[2] = '{0, 8'h00, 9, {8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h22, 8'h0}, 10'h322};
        tbl[3] = '{0, 8'h00, 10, {5{16'h0BC0}}, 10'h000};
        tbl[4] = '{0, 8'h00, 6, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h3C, 8'hBC, 32'h0}, 10'h23C};
        tbl[5] = '{7, 8'h2A, 5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h5A, 40'h0}, 10'h35A};

        reset       = 1'b1;
        bus.data_in = 1'b0;

        tag = "reset";
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1);
            check("reset_hold", dut_out(), 10'h000);
        end
        step(1'($urandom_range(0, 1)), 1'b0);
        check("reset_release", dut_out(), 10'h000);

        tag = "clean";
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hBC); send_byte(8'h7E);
        check("clean_e30", obs[30], 10'h000);
        check("clean_e31", obs[31], 10'h200);
        check("clean_e38", obs[38], 10'h200);
        for (int e = 39; e <= 46; e++) check("clean_A5_hold", obs[e], 10'h3A5);
        check("clean_e47", obs[47], 10'h33C);
        check("clean_comma_idle", obs[55], 10'h23C);
        check("clean_e63", obs[63], 10'h37E);

        tag = "broken";
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h55);
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
        send_byte(8'h22);
        check("broken_after_55", obs[31], 10'h000);
        check("broken_e62", obs[62], 10'h000);
        check("broken_relock", obs[63], 10'h200);
        check("broken_22", obs[71], 10'h322);

        for (int v = 0; v < 6; v++) begin
            tag = $sformatf("table%0d", v);
            do_reset();
            for (int i = tbl[v].npre - 1; i >= 0; i--) step(tbl[v].pre[i], 1'b0);
            for (int j = 0; j < tbl[v].nbytes; j++) send_byte(tbl[v].bytes[79 - 8 * j -: 8]);
            check($sformatf("table%0d_end", v), dut_out(), tbl[v].exp);
        end

        tag = "midreset";
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
        send_byte(8'hA5);
        check("midreset_before", dut_out(), 10'h3A5);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("midreset_cleared", dut_out(), 10'h000);
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
        check("midreset_relock", dut_out(), 10'h200);
        send_byte(8'h99);
        check("midreset_99", dut_out(), 10'h399);

        tag = "random";
        for (int t = 0; t < 8; t++) begin
            do_reset();
            nj = $urandom_range(0, 7);
            for (int i = 0; i < nj; i++) step(1'($urandom_range(0, 1)), 1'b0);
            for (int j = 0; j < 40; j++) begin
                rb = ($urandom_range(0, 3) < 2) ? M_COMMA : 8'($urandom);
                for (int i = 7; i >= 0; i--) begin
                    if ($urandom_range(0, 399) == 0) step(1'b0, 1'b1);
                    step(rb[i], 1'b0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
